// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Loads are staged and committed only at the frame wrap, so a frame is never torn.
module seg7_scan_driver #(
  parameter int TICK_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  en_in,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(TICK_DIV - 1);

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic             pending_q, pending_d;
  logic [31:0]      stage_data_q, stage_data_d;
  logic [7:0]       stage_dp_q, stage_dp_d;
  logic [7:0]       stage_en_q, stage_en_d;
  logic [31:0]      shadow_data_q, shadow_data_d;
  logic [7:0]       shadow_dp_q, shadow_dp_d;
  logic [7:0]       shadow_en_q, shadow_en_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;
  logic             tick;
  logic             wrap;
  logic             commit;

  // Next-state logic for divider, scan index, staging/shadow and output drive.
  always_comb begin
    tick          = (div_q == DIV_MAX);
    wrap          = tick && (idx_q == 3'd7);
    commit        = wrap && pending_q;
    div_d         = div_q;
    idx_d         = idx_q;
    pending_d     = pending_q;
    stage_data_d  = stage_data_q;
    stage_dp_d    = stage_dp_q;
    stage_en_d    = stage_en_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    shadow_en_d   = shadow_en_q;
    an_d          = 8'hFF;
    seg_d         = 7'h7F;
    dp_d          = 1'b1;
    frame_done_d  = wrap;

    if (tick) begin
      div_d = {CNT_W{1'b0}};
      idx_d = idx_q + 3'd1;
    end else begin
      div_d = div_q + CNT_W'(1);
      idx_d = idx_q;
    end

    // Commit reads the pre-edge staging, so a coincident load waits a frame.
    if (commit) begin
      shadow_data_d = stage_data_q;
      shadow_dp_d   = stage_dp_q;
      shadow_en_d   = stage_en_q;
    end else begin
      shadow_data_d = shadow_data_q;
    end

    if (load) begin
      stage_data_d = data;
      stage_dp_d   = dp_in;
      stage_en_d   = en_in;
      pending_d    = 1'b1;
    end else if (commit) begin
      pending_d    = 1'b0;
    end else begin
      pending_d    = pending_q;
    end

    if (shadow_en_q[idx_q]) begin
      an_d  = ~(8'b0000_0001 << idx_q);
      seg_d = hex_decode(shadow_data_q[{idx_q, 2'b00} +: 4]);
      dp_d  = ~shadow_dp_q[idx_q];
    end else begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= {CNT_W{1'b0}};
      idx_q         <= 3'd0;
      pending_q     <= 1'b0;
      stage_data_q  <= 32'h0000_0000;
      stage_dp_q    <= 8'h00;
      stage_en_q    <= 8'h00;
      shadow_data_q <= 32'h0000_0000;
      shadow_dp_q   <= 8'h00;
      shadow_en_q   <= 8'h00;
      an_q          <= 8'hFF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      div_q         <= div_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      stage_data_q  <= stage_data_d;
      stage_dp_q    <= stage_dp_d;
      stage_en_q    <= stage_en_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_en_q   <= shadow_en_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with TICK_DIV=4: the driver pushes expected
// outputs per edge (reference model plus hand-written slot values), a monitor pops and compares.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] data = 32'h0000_0000;
  logic [7:0]  dp_in = 8'h00;
  logic [7:0]  en_in = 8'h00;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        frame_done;

  seg7_scan_driver #(.TICK_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in), .en_in(en_in),
    .AN(AN), .SEG(SEG), .DP(DP), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    string      name;
  } exp_t;

  typedef struct {
    int          k;
    logic [31:0] d;
    logic [7:0]  dp;
    logic [7:0]  en;
  } ld_t;

  localparam logic [6:0] HEX_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  exp_t sb[$];
  ld_t  lq[$];
  int   abs_cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: k = edges since reset release.
  int          k = 0;
  logic [31:0] st_d = 32'h0, sh_d = 32'h0;
  logic [7:0]  st_dp = 8'h0, st_en = 8'h0, sh_dp = 8'h0, sh_en = 8'h0;
  logic        pend = 1'b0;

  always @(posedge clk) abs_cyc <= abs_cyc + 1;

  // Monitor: pops every expectation due at this edge and compares.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag <= abs_cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (e.tag < abs_cyc) begin
        n_fail++;
        $display("FAIL %s stale tag=%0d at cycle %0d", e.name, e.tag, abs_cyc);
      end else if ({AN, SEG, DP, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
        n_fail++;
        $display("FAIL %s tag=%0d: got AN=%h SEG=%h DP=%b fd=%b, want AN=%h SEG=%h DP=%b fd=%b",
                 e.name, e.tag, AN, SEG, DP, frame_done, e.an, e.seg, e.dp, e.fd);
      end
    end
  end

  task automatic sched_load(input int at_k, input logic [31:0] d, input logic [7:0] dpv,
                            input logic [7:0] env);
    ld_t l;
    l.k = at_k; l.d = d; l.dp = dpv; l.en = env;
    lq.push_back(l);
  endtask

  // One clock: drive inputs for the next edge and push the model's expectation for it.
  task automatic cyc(input logic r);
    ld_t  l;
    exp_t e;
    logic ld;
    int   k1, ip;
    ld = 1'b0;
    l.k = 0; l.d = 32'h0; l.dp = 8'h0; l.en = 8'h0;
    k1 = r ? 0 : k + 1;
    if (!r && lq.size() > 0 && lq[0].k == k1) begin
      l  = lq.pop_front();
      ld = 1'b1;
    end
    rst = r; load = ld; data = l.d; dp_in = l.dp; en_in = l.en;
    e.tag = abs_cyc + 1;
    e.name = "model";
    if (r) begin
      e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0;
      st_d = 32'h0; st_dp = 8'h0; st_en = 8'h0;
      sh_d = 32'h0; sh_dp = 8'h0; sh_en = 8'h0;
      pend = 1'b0;
    end else begin
      ip = (k >> 2) & 7;
      if (sh_en[ip]) begin
        e.an  = ~(8'h01 << ip);
        e.seg = HEX_TAB[sh_d[ip*4 +: 4]];
        e.dp  = ~sh_dp[ip];
      end else begin
        e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
      end
      e.fd = (k1 % 32 == 0);
      if (e.fd && pend) begin
        sh_d = st_d; sh_dp = st_dp; sh_en = st_en; pend = 1'b0;
      end
      if (ld) begin
        st_d = l.d; st_dp = l.dp; st_en = l.en; pend = 1'b1;
      end
    end
    k = k1;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (k < target) cyc(1'b0);
  endtask

  // Runs one frame from a wrap point, adding hand-written values at each slot's first clock.
  task automatic run_frame(input string nm, input logic [7:0][6:0] hs, input logic [7:0] hdp,
                           input logic [7:0] hen);
    exp_t e;
    for (int c = 0; c < 32; c++) begin
      if (c % 4 == 0) begin
        int j;
        j = c / 4;
        e.tag  = abs_cyc + 1;
        e.name = nm;
        e.fd   = 1'b0;
        if (hen[j]) begin
          e.an = ~(8'h01 << j); e.seg = hs[j]; e.dp = ~hdp[j];
        end else begin
          e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
        end
        sb.push_back(e);
      end
      cyc(1'b0);
    end
  endtask

  localparam logic [7:0][6:0] HS_CNT = {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  localparam logic [7:0][6:0] HS_F   = {8{7'h0E}};
  localparam logic [7:0][6:0] HS_A   = {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h40};
  localparam logic [7:0][6:0] HS_B   = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h08};
  localparam logic [7:0][6:0] HS_2   = {8{7'h24}};
  localparam logic [7:0][6:0] HS_4   = {8{7'h19}};

  initial begin
    cyc(1'b1);
    cyc(1'b1);
    run_frame("reset_blank", HS_CNT, 8'h00, 8'h00);

    sched_load(34, 32'h7654_3210, 8'h01, 8'hFF);
    run_to(64);
    run_frame("basic_scan", HS_CNT, 8'h01, 8'hFF);

    sched_load(98, 32'h7654_3210, 8'h00, 8'hAA);
    run_to(128);
    run_frame("blanking", HS_CNT, 8'h00, 8'hAA);

    sched_load(162, 32'h7654_3210, 8'h00, 8'hFF);
    sched_load(205, 32'hFFFF_FFFF, 8'h00, 8'hFF);
    run_to(192);
    run_frame("tearfree_old", HS_CNT, 8'h00, 8'hFF);

    sched_load(250, 32'h89AB_CDE0, 8'h81, 8'hFF);
    sched_load(256, 32'h1234_567A, 8'h00, 8'h7F);
    run_frame("tearfree_new", HS_F, 8'h00, 8'hFF);

    sched_load(295, 32'h1111_1111, 8'h00, 8'hFF);
    sched_load(300, 32'h2222_2222, 8'hFF, 8'hFF);
    run_frame("coincide_a", HS_A, 8'h81, 8'hFF);
    run_frame("coincide_b", HS_B, 8'h00, 8'h7F);
    run_frame("double_load", HS_2, 8'hFF, 8'hFF);

    sched_load(362, 32'h3333_3333, 8'h00, 8'hFF);
    run_to(372);
    cyc(1'b1);
    run_frame("midreset_blank0", HS_CNT, 8'h00, 8'h00);
    run_frame("midreset_blank1", HS_CNT, 8'h00, 8'h00);

    sched_load(70, 32'h4444_4444, 8'h5A, 8'h0F);
    run_to(96);
    run_frame("after_reset_load", HS_4, 8'h5A, 8'h0F);

    @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
